// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the instruction-fetch slice.
package mips_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Storage is cleared on reset so the head never presents X while empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the combinational ROM and queues
// {pc, instr} pairs for decode; redirects flush the queue and restart fetch.
module imem_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int              PC_W     = mips_pkg::PC_W,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [PC_W-3:0]    imem_addr,
    input  logic [31:0]        imem_instr,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               misalign
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]        fetch_pc;
    entry_t                 wr_entry;
    entry_t                 head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop;
    logic                   fetch_en;

    // A redirect suppresses both ends of the queue; the flush owns that edge.
    assign pop      = ~fifo_empty & out_ready & ~redirect;
    assign fetch_en = reset_n & ~redirect & (~fifo_full | pop);

    assign wr_entry  = '{pc: fetch_pc, instr: imem_instr};
    assign imem_addr = fetch_pc[PC_W-1:2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            misalign <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                misalign <= 1'b1;
            end
        end else if (fetch_en) begin
            fetch_pc <= fetch_pc + PC_W'(4);
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect),
        .push    (fetch_en),
        .pop     (pop),
        .din     (wr_entry),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the processor's combinational instruction ROM: owns the fetch PC and drives the ROM word address.
- Captures each returned instruction, with its PC, into a small prefetch buffer and presents it to decode over a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the buffer and restarting fetch at the target.
- Sits between the ROM and the decode/execute stage, decoupling ROM access from decode stalls.

Parameters:
- PC_W, 8, byte-address width of the PC; ROM word address is PC_W-2 bits (6 at default).
- DEPTH, 2, prefetch buffer entries (power of two, 2..8).
- RESET_PC, 8'h00, fetch PC loaded at reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- imem_addr  out  PC_W-2  ROM word address = fetch_pc[PC_W-1:2].
- imem_instr  in  32  ROM read data, combinational from imem_addr.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  PC_W  byte target for a redirect.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  PC_W  byte PC of the head instruction.
- misalign  out  1  sticky flag: a redirect target had pc[1:0] != 0.

Behaviour:
- Reset (reset_n=0 at the edge):
  - fetch_pc = RESET_PC.
  - Buffer empty: count=0, read/write pointers 0.
  - out_valid=0, misalign=0.
  - Reset overrides redirect and any in-flight fetch, mid-operation included.
- Outputs at reset:
  - out_instr/out_pc are don't-care while out_valid=0 but must not be X (drive the head register, reset to 0).
  - imem_addr follows fetch_pc, so it reads RESET_PC[PC_W-1:2] during reset.
- pop = out_valid & out_ready & ~redirect.
- fetch_en = reset_n & ~redirect & (count<DEPTH | pop).
- Each cycle with fetch_en=1:
  - Push {fetch_pc, imem_instr} at the edge.
  - fetch_pc += 4; wraps modulo 2^PC_W, so 8'hFC goes to 8'h00.
- Simultaneous push and pop when full is allowed; count is unchanged.
- Latency:
  - The first instruction after reset release is visible with out_valid=1 one cycle after the first fetch edge.
  - Steady-state throughput is 1 instruction/cycle with out_ready held high.
- Redirect at cycle t:
  - At edge t the buffer is flushed (count=0) and fetch_pc = {redirect_pc[PC_W-1:2], 2'b00}.
  - No push and no pop at that edge. A head handshake coinciding with the redirect is discarded; the consumer owns that ordering.
  - Cycle t+1 fetches the target; out_valid=1 with out_pc=target at t+2.
  - Back-to-back redirects: the last one wins and nothing is pushed in between.
- misalign: set when redirect=1 and redirect_pc[1:0]!=0; cleared only by reset. Fetch proceeds at the aligned address.
- Stall: with out_ready=0 the buffer fills to DEPTH, fetch_en drops, and fetch_pc holds. Head outputs stay stable while out_valid=1 and out_ready=0.
- Empty: out_valid=0, and out_ready is ignored.
- ROM X data (unmapped address) is stored as-is; this block performs no checking.

Decomposition:
- Shared package mips_pkg holds:
  - the PC_W default and RESET_PC constant;
  - a packed struct fetch_entry_t {logic [PC_W-1:0] pc; logic [31:0] instr;};
  - the localparam INSTR_W=32.
- One natural sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t with DEPTH, push, pop, flush, full, empty and count ports.
- The controller wraps fetch_fifo with the PC register, the fetch_en logic and the misalign flag.

Test Plan:
- Reset release, out_ready=1, ROM model returning instr=pc|32'hA000_0000:
  - out_pc sequence 00,04,08,0C… on consecutive cycles, first out_valid exactly 1 cycle after the first fetch.
- Hold out_ready=0 for 6 cycles after the first valid:
  - count saturates at 2, fetch_pc frozen at 08, out_pc stays 00.
  - On release, out_pc 00,04,08 with no gaps or duplicates.
- Redirect to 8'h44 while the buffer is full:
  - Next out_valid occurs 2 cycles later with out_pc=44, followed by 48.
  - The stale 04/08 entries are never presented.
- redirect_pc=8'h4E:
  - Fetch resumes at 4C and misalign=1 stays set until reset.
- Run from 8'hF8 (set via redirect):
  - out_pc sequence F8,FC,00,04, confirming PC wrap.
- Assert reset_n=0 mid-stream with a redirect the same cycle:
  - Buffer empty, out_valid=0, misalign=0, and the first post-reset out_pc=RESET_PC.
